fib_ctrl: RTL and testbench
===========================

FIB_CTRL -- requirements
Module: fib_ctrl

Interface
REQ-001 Parameter BW, default 8: datapath width; must match the attached function unit.
REQ-002 Parameter FS_ADD, default 5'b00000: fs code selecting two-operand add on the function unit; fs[4]=0 (ALU path).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 n  input  BW  term index; captured with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when the result is valid.
REQ-009 result  output  BW  F(n), or last valid term on overflow; held until next accepted start.
REQ-010 ovf  output  1  overflow flag; held with result.
REQ-011 opa, opb  output  BW each  operands to function unit.
REQ-012 fs  output  5  function select to function unit.
REQ-013 rw  output  1  status-register write enable to function unit.
REQ-014 fout  input  BW  function unit result; combinational from opa/opb/fs in the same cycle.
REQ-015 psw  input  4  registered status; bit1 = carry; updated on the edge where rw=1.
REQ-016 out_valid, out_data[BW], out_ready  per-term stream (see Configuration).

Function
REQ-017 States IDLE, ADD, CHK, WAIT, DONE; internal registers a, b, sum (BW bits), cnt (BW bits).
REQ-018 IDLE with start=1: a<=0, b<=1, cnt<=n-1, ovf<=0; next ADD if n>=2, else DONE.
REQ-019 ADD (one cycle): opa=a, opb=b, fs=FS_ADD, rw=1; sum<=fout; next CHK.
REQ-020 Outside ADD: opa=0, opb=0, fs=0, rw=0.
REQ-021 CHK, psw[1]=1: ovf<=1, a/b unchanged, next DONE.
REQ-022 CHK, psw[1]=0: a<=b, b<=sum, cnt<=cnt-1; next WAIT if streaming enabled, else DONE if cnt==1, else ADD.
REQ-023 WAIT: out_valid=1, out_data=b; on out_ready=1 next DONE if cnt==0, else ADD.
REQ-024 DONE (one cycle): done=1; result<=0 if captured n==0, else b; next IDLE.
REQ-025 Latency, no overflow, streaming disabled: start accepted at edge T, done high in cycle T+2(n-1)+1 for n>=2, T+1 for n<2.
REQ-026 start while busy is ignored; n change while busy has no effect.
REQ-027 n==1 yields result 1, no function-unit transaction; n==0 yields result 0.
REQ-028 Arithmetic modulo 2^BW; overflow detected only via psw[1], never by local compare.

Reset
REQ-029 rst asserted: state IDLE; busy, done, ovf, rw, out_valid = 0; result, opa, opb, fs, out_data, a, b, sum, cnt = 0.
REQ-030 rst mid-operation aborts immediately; no done pulse is produced for the aborted request.

Configuration
REQ-031 Macro FIB_STREAM_EN defined: WAIT state present; each committed term F(2)..F(n) presented on out_valid/out_data, stalling until out_ready.
REQ-032 FIB_STREAM_EN undefined: WAIT omitted; out_valid and out_data tied 0; out_ready ignored; REQ-025 latency applies.

Verification
REQ-033 BW=8, n=0, start -> done at T+1, result=0, ovf=0, rw never high.
REQ-034 BW=8, n=10 -> rw high 9 times, done at T+19, result=55, ovf=0.
REQ-035 BW=8, n=14 -> carry on 13th add (233+144), result=233, ovf=1.
REQ-036 Reset asserted in CHK during n=10 run -> all outputs 0 same cycle; subsequent n=5 run gives result=5.
REQ-037 start pulsed again mid-run with n=3 during n=10 run -> ignored, result=55.
REQ-038 FIB_STREAM_EN, n=6, out_ready low 3 cycles per term -> out_data sequence 1,2,3,5,8, each held while stalled; result=8.

Source files
------------

// File: rtl/fib_ctrl_if.sv
// Bundle of the fib_ctrl request/result handshake, the function-unit port and the
// optional per-term stream. The slave modport is the controller's side of every signal.
//
// Handshakes: start is a request sampled only while busy is low. done is a one-cycle
// strobe that qualifies result/ovf. The stream follows strict valid/ready rules:
// once out_valid rises, out_data is held stable until a cycle with out_ready=1, and
// the term transfers on that cycle's rising edge.
interface fib_ctrl_if #(
  parameter int BW = 8
);
  logic          start;
  logic [BW-1:0] n;
  logic          busy;
  logic          done;
  logic [BW-1:0] result;
  logic          ovf;
  logic [BW-1:0] opa;
  logic [BW-1:0] opb;
  logic [4:0]    fs;
  logic          rw;
  logic [BW-1:0] fout;
  logic [3:0]    psw;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_ready;

  modport slave (
    input  start, n, fout, psw, out_ready,
    output busy, done, result, ovf, opa, opb, fs, rw, out_valid, out_data
  );

  modport master (
    output start, n, fout, psw, out_ready,
    input  busy, done, result, ovf, opa, opb, fs, rw, out_valid, out_data
  );
endinterface

// File: rtl/fib_ctrl.sv
// Fibonacci sequencer that drives an external ALU one add at a time and uses its carry flag
// for overflow. Optional macro FIB_STREAM_EN adds a WAIT state that streams each term.
module fib_ctrl #(
  parameter int         BW     = 8,
  parameter logic [4:0] FS_ADD = 5'b00000
) (
  input  logic          clk,
  input  logic          rst,
  fib_ctrl_if.slave     bus,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    CHK  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic [BW-1:0] sum;
  logic [BW-1:0] cnt;

  assign dbg_state = state;

  // Only the carry bit of the status word matters here.
  logic unused_psw;
  assign unused_psw = ^{bus.psw[3:2], bus.psw[0]};

`ifndef FIB_STREAM_EN
  logic unused_ready;
  assign unused_ready  = bus.out_ready;
  assign bus.out_valid = 1'b0;
  assign bus.out_data  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      sum        <= '0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.ovf    <= 1'b0;
      bus.opa    <= '0;
      bus.opb    <= '0;
      bus.fs     <= '0;
      bus.rw     <= 1'b0;
`ifdef FIB_STREAM_EN
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a        <= '0;
            b        <= BW'(1);
            cnt      <= bus.n - BW'(1);
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b1;
            if (bus.n >= BW'(2)) begin
              state   <= ADD;
              bus.opa <= '0;
              bus.opb <= BW'(1);
              bus.fs  <= FS_ADD;
              bus.rw  <= 1'b1;
            end else begin
              // n==0 and n==1 finish without touching the function unit.
              state      <= DONE;
              bus.done   <= 1'b1;
              bus.result <= (bus.n == '0) ? '0 : BW'(1);
            end
          end
        end

        ADD: begin
          sum     <= bus.fout;
          bus.opa <= '0;
          bus.opb <= '0;
          bus.fs  <= '0;
          bus.rw  <= 1'b0;
          state   <= CHK;
        end

        CHK: begin
          if (bus.psw[1]) begin
            bus.ovf    <= 1'b1;
            bus.done   <= 1'b1;
            bus.result <= b;
            state      <= DONE;
          end else begin
            a   <= b;
            b   <= sum;
            cnt <= cnt - BW'(1);
`ifdef FIB_STREAM_EN
            bus.out_valid <= 1'b1;
            bus.out_data  <= sum;
            state         <= WAIT;
`else
            if (cnt == BW'(1)) begin
              bus.done   <= 1'b1;
              bus.result <= sum;
              state      <= DONE;
            end else begin
              bus.opa <= b;
              bus.opb <= sum;
              bus.fs  <= FS_ADD;
              bus.rw  <= 1'b1;
              state   <= ADD;
            end
`endif
          end
        end

`ifdef FIB_STREAM_EN
        WAIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            if (cnt == '0) begin
              bus.done   <= 1'b1;
              bus.result <= b;
              state      <= DONE;
            end else begin
              bus.opa <= a;
              bus.opb <= b;
              bus.fs  <= FS_ADD;
              bus.rw  <= 1'b1;
              state   <= ADD;
            end
          end
        end
`endif

        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_ctrl.sv
// Directed bench for fib_ctrl: table of n -> result/ovf/latency/add-count vectors plus
// hand-written sequences for restart-while-busy, reset mid-run and the term stream.
module tb_fib_ctrl;

  localparam int BW = 8;
`ifdef FIB_STREAM_EN
  localparam int STREAM_EXTRA = 1;
`else
  localparam int STREAM_EXTRA = 0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  fib_ctrl_if #(.BW(BW)) bus ();

  fib_ctrl #(.BW(BW), .FS_ADD(5'b00000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function-unit model: combinational add, carry latched into psw[1] when rw is high.
  logic [BW:0] wide_sum;
  assign wide_sum = {1'b0, bus.opa} + {1'b0, bus.opb};
  assign bus.fout = (bus.fs == 5'b00000) ? wide_sum[BW-1:0] : '0;
  always @(posedge clk or posedge rst) begin
    if (rst) bus.psw <= 4'b0000;
    else if (bus.rw) bus.psw <= {2'b00, wide_sum[BW], 1'b0};
  end

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0;
  logic [BW-1:0] exp_q[$];

  always @(negedge clk) if (bus.out_valid) ov_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: issue one request and follow it to done; optionally re-pulse start mid-run.
  task automatic run_fib(input logic [BW-1:0] nv, input int poke_at,
                         output int cyc, output int rws, output logic got);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.n     = BW'($urandom_range(0, 255));
    cyc = 0;
    rws = 0;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (poke_at != 0 && cyc == poke_at) begin
        bus.start = 1'b1;
        bus.n     = 8'd3;
      end else if (poke_at != 0 && cyc == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.rw) rws++;
      if (bus.done) got = 1'b1;
    end
  endtask

  typedef struct {
    logic [BW-1:0] n;
    int            poke;
    logic [BW-1:0] exp_result;
    logic          exp_ovf;
    int            exp_cyc;
    int            exp_rw;
    int            exp_terms;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int            cyc;
    int            rws;
    logic          got;
    logic [BW-1:0] exp_d;
    int            done_seen;

    vecs[0] = '{8'd0,   0, 8'd0,   1'b0,  1,  0,  0};
    vecs[1] = '{8'd1,   0, 8'd1,   1'b0,  1,  0,  0};
    vecs[2] = '{8'd2,   0, 8'd1,   1'b0,  3,  1,  1};
    vecs[3] = '{8'd3,   0, 8'd2,   1'b0,  5,  2,  2};
    vecs[4] = '{8'd10,  0, 8'd55,  1'b0, 19,  9,  9};
    vecs[5] = '{8'd13,  0, 8'd233, 1'b0, 25, 12, 12};
    vecs[6] = '{8'd14,  0, 8'd233, 1'b1, 27, 13, 12};
    vecs[7] = '{8'd255, 0, 8'd233, 1'b1, 27, 13, 12};
    vecs[8] = '{8'd10,  4, 8'd55,  1'b0, 19,  9,  9};
    vecs[9] = '{8'd5,   0, 8'd5,   1'b0,  9,  4,  4};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.n         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(bus.busy),   0);
    check("reset_done",   32'(bus.done),   0);
    check("reset_result", 32'(bus.result), 0);
    check("reset_rw",     32'(bus.rw),     0);
    check("reset_state",  32'(dbg_state),  0);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_fib(vecs[v].n, vecs[v].poke, cyc, rws, got);
      check($sformatf("v%0d_done_seen", v), 32'(got), 1);
      check($sformatf("v%0d_latency", v), 32'(cyc),
            32'(vecs[v].exp_cyc + STREAM_EXTRA * vecs[v].exp_terms));
      check($sformatf("v%0d_result", v), 32'(bus.result), 32'(vecs[v].exp_result));
      check($sformatf("v%0d_ovf", v), 32'(bus.ovf), 32'(vecs[v].exp_ovf));
      check($sformatf("v%0d_rw_count", v), 32'(rws), 32'(vecs[v].exp_rw));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), 32'(bus.done), 0);
      check($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 0);
      check($sformatf("v%0d_result_held", v), 32'(bus.result), 32'(vecs[v].exp_result));
    end

    // Reset while the n=10 run sits in CHK: outputs clear at once, no done follows.
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 50 && dbg_state != 3'd2; i++) @(negedge clk);
    check("abort_reached_chk", 32'(dbg_state), 2);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   32'(bus.busy),   0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_ovf",    32'(bus.ovf),    0);
    check("abort_opb",    32'(bus.opb),    0);
    check("abort_state",  32'(dbg_state),  0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 0);
    run_fib(8'd5, 0, cyc, rws, got);
    check("after_abort_done", 32'(got), 1);
    check("after_abort_result", 32'(bus.result), 5);

`ifdef FIB_STREAM_EN
    // Stalled stream: each term held for three not-ready cycles before it is taken.
    exp_q = {8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
      check($sformatf("term%0d_valid", k), 32'(bus.out_valid), 1);
      exp_d = exp_q.pop_front();
      check($sformatf("term%0d_data", k), 32'(bus.out_data), 32'(exp_d));
      repeat (3) begin
        @(negedge clk);
        check($sformatf("term%0d_stall_valid", k), 32'(bus.out_valid), 1);
        check($sformatf("term%0d_stall_data", k), 32'(bus.out_data), 32'(exp_d));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check("stream_done", 32'(bus.done), 1);
    check("stream_result", 32'(bus.result), 8);
    check("stream_ovf", 32'(bus.ovf), 0);
    bus.out_ready = 1'b1;
`else
    check("no_stream_valid", 32'(ov_cnt), 0);
    check("no_stream_data", 32'(bus.out_data), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
